sprite_layer: RTL and testbench
===============================

SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4, number of independent sprite channels (1..8).
REQ-002 SHALL have parameter SPRITE_SIZE, default 32, sprite edge in pixels (power of two).
REQ-003 SHALL have parameter DATA_WIDTH, default 8, pixel colour width.
REQ-004 SHALL have parameter COORD_WIDTH, default 11, screen coordinate width.
REQ-005 SHALL have parameter TRANSPARENT, default 0, colour value treated as see-through.
REQ-006 SHALL have parameter MEMFILE, default "", hex image preloaded into all sprite RAMs when non-empty.
REQ-007 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports: i_pix_valid  in  1  scan pixel present; i_x, i_y  in  COORD_WIDTH  scan coordinate.
REQ-009 SHALL have ports: i_sel  in  clog2(NUM_SPRITES)  sprite targeted by config/write; i_pos_we  in  1  position/enable update strobe; i_pos_x, i_pos_y  in  COORD_WIDTH  new top-left; i_en  in  1  new enable.
REQ-010 SHALL have ports: i_wr  in  1  sprite RAM write strobe; i_wr_addr  in  clog2(SPRITE_SIZE^2)  texel address; i_wr_data  in  DATA_WIDTH  texel.
REQ-011 SHALL have ports: i_clr_coll  in  1  clear sticky collision; o_pix_valid  out  1; o_data  out  DATA_WIDTH  composited pixel; o_hit  out  1  opaque sprite pixel present; o_id  out  clog2(NUM_SPRITES)  winning sprite; o_coll  out  1  per-pixel overlap; o_coll_sticky  out  1  latched overlap.

Function
REQ-012 SHALL hold per sprite a position register (x, y) and enable bit, written from i_pos_x/i_pos_y/i_en on clk edge when i_pos_we=1 for sprite i_sel.
REQ-013 SHALL hold per sprite a SPRITE_SIZE^2 x DATA_WIDTH RAM with independent write port (i_wr, i_sel, i_wr_addr) and synchronous read port.
REQ-014 SHALL declare sprite s inside when enabled and pos_x<=i_x<pos_x+SPRITE_SIZE and pos_y<=i_y<pos_y+SPRITE_SIZE, sums computed in COORD_WIDTH+1 bits (no wrap at screen edge).
REQ-015 SHALL read address (i_y-pos_y)*SPRITE_SIZE+(i_x-pos_x) when inside, else address 0.
REQ-016 SHALL be a 2-stage pipeline: cycle N inputs -> RAM read and inside-flags registered at N+1 -> composite outputs registered at N+2; o_pix_valid equals i_pix_valid delayed 2 cycles.
REQ-017 SHALL mark sprite s opaque when inside and texel != TRANSPARENT.
REQ-018 SHALL select the lowest-index opaque sprite: o_hit=1, o_id=index, o_data=texel; with none, o_hit=0, o_id=0, o_data=TRANSPARENT.
REQ-019 SHALL assert o_coll when two or more sprites are opaque on the same pixel and o_pix_valid=1.
REQ-020 SHALL set o_coll_sticky on any cycle o_coll=1 and clear it on i_clr_coll=1; simultaneous set and clear SHALL leave it set.
REQ-021 SHALL apply a position/enable update to pixels presented from the cycle after the write edge; pixels already in flight are unaffected.
REQ-022 SHALL return old RAM data when a write and a read hit the same texel in the same cycle.
REQ-023 SHALL ignore i_pos_we and i_wr when i_sel>=NUM_SPRITES.
REQ-024 SHALL force o_hit=0, o_coll=0 and o_data=TRANSPARENT when the delayed valid is 0.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously clear all positions to 0, all enables to 0, pipeline valids to 0, o_data to TRANSPARENT, o_hit/o_id/o_coll/o_coll_sticky to 0.
REQ-026 SHALL not clear sprite RAM contents on reset.
REQ-027 SHALL, when reset is asserted mid-frame, drop all in-flight pixels; the first o_pix_valid after release SHALL follow the first post-release i_pix_valid by exactly 2 cycles.

Verification
REQ-028 Sprite 0 at (100,50), RAM[0]=8'h3C, enabled; scan (100,50) at cycle N -> cycle N+2 o_pix_valid=1, o_data=8'h3C, o_hit=1, o_id=0.
REQ-029 Sprite 0 at (100,50); scan (132,50) and (99,50) -> o_hit=0, o_data=TRANSPARENT.
REQ-030 Sprites 0 and 1 both at (10,10), RAM0[0]=0, RAM1[0]=8'h55; scan (10,10) -> o_data=8'h55, o_id=1, o_coll=0; set RAM0[0]=8'hAA -> o_data=8'hAA, o_id=0, o_coll=1, o_coll_sticky stays 1 until i_clr_coll.
REQ-031 Sprite at (2040,0), COORD_WIDTH=11; scan (2047,0) -> hit on texel 7; scan (0,0) -> no hit (no wrap).
REQ-032 Stream valid pixels, pulse rst_n low for 1 cycle mid-stream -> outputs 0 immediately, enables cleared, o_hit=0 on all later pixels until reconfigured.

Source files
------------

// File: rtl/sprite_layer.sv
// Hardware sprite compositor: per-sprite position/enable registers and texel RAMs,
// two-stage pipeline from scan coordinate to composited pixel with collision flags.
module sprite_layer #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int COORD_WIDTH = 11,
  parameter int TRANSPARENT = 0,
  parameter     MEMFILE     = "",
  localparam int SEL_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int LOG_S      = $clog2(SPRITE_SIZE),
  localparam int ADDR_W     = 2 * LOG_S
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_pix_valid,
  input  logic [COORD_WIDTH-1:0] i_x,
  input  logic [COORD_WIDTH-1:0] i_y,
  input  logic [SEL_W-1:0]       i_sel,
  input  logic                   i_pos_we,
  input  logic [COORD_WIDTH-1:0] i_pos_x,
  input  logic [COORD_WIDTH-1:0] i_pos_y,
  input  logic                   i_en,
  input  logic                   i_wr,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [DATA_WIDTH-1:0]  i_wr_data,
  input  logic                   i_clr_coll,
  output logic                   o_pix_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_hit,
  output logic [SEL_W-1:0]       o_id,
  output logic                   o_coll,
  output logic                   o_coll_sticky
);

  localparam int                    DEPTH  = SPRITE_SIZE * SPRITE_SIZE;
  localparam logic [DATA_WIDTH-1:0] TRANSP = DATA_WIDTH'(TRANSPARENT);

  logic [COORD_WIDTH-1:0] r_pos_x [NUM_SPRITES];
  logic [COORD_WIDTH-1:0] r_pos_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_en;

  logic                   r_v1;
  logic [NUM_SPRITES-1:0] r_inside1;

  logic [NUM_SPRITES-1:0]                 w_inside;
  logic [NUM_SPRITES-1:0]                 w_opaque;
  logic [NUM_SPRITES-1:0][DATA_WIDTH-1:0] w_texel;

  logic                  r_pix_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_hit;
  logic [SEL_W-1:0]      r_id;
  logic                  r_coll;
  logic                  r_coll_sticky;

  // Per-sprite hit test, texel RAM and read register
  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_sprite
    logic [COORD_WIDTH:0]  w_x_end;
    logic [COORD_WIDTH:0]  w_y_end;
    logic [LOG_S-1:0]      w_dx;
    logic [LOG_S-1:0]      w_dy;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_texel;

    // Extra top bit keeps a sprite near the right/bottom edge from wrapping to 0
    assign w_x_end = {1'b0, r_pos_x[s]} + (COORD_WIDTH+1)'(SPRITE_SIZE);
    assign w_y_end = {1'b0, r_pos_y[s]} + (COORD_WIDTH+1)'(SPRITE_SIZE);
    assign w_dx    = i_x[LOG_S-1:0] - r_pos_x[s][LOG_S-1:0];
    assign w_dy    = i_y[LOG_S-1:0] - r_pos_y[s][LOG_S-1:0];

    assign w_inside[s] = r_en[s]
                      && (i_x >= r_pos_x[s]) && ({1'b0, i_x} < w_x_end)
                      && (i_y >= r_pos_y[s]) && ({1'b0, i_y} < w_y_end);
    assign w_rd_addr   = w_inside[s] ? {w_dy, w_dx} : '0;

    // NOTE: RAM has no reset so it maps onto block RAM; contents survive rst_n.
    // NOTE: non-blocking write means a same-cycle read of the same texel sees old data.
    always_ff @(posedge clk) begin
      if (i_wr && (i_sel == SEL_W'(s))) r_mem[i_wr_addr] <= i_wr_data;
      r_texel <= r_mem[w_rd_addr];
    end

    assign w_texel[s]  = r_texel;
    assign w_opaque[s] = r_inside1[s] && (r_texel != TRANSP);
  end

  // Position/enable registers and stage-1 valid/inside flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        r_pos_x[s] <= '0;
        r_pos_y[s] <= '0;
      end
      r_en      <= '0;
      r_v1      <= 1'b0;
      r_inside1 <= '0;
    end else begin
      for (int s = 0; s < NUM_SPRITES; s++) begin
        if (i_pos_we && (i_sel == SEL_W'(s))) begin
          r_pos_x[s] <= i_pos_x;
          r_pos_y[s] <= i_pos_y;
          r_en[s]    <= i_en;
        end
      end
      r_v1      <= i_pix_valid;
      r_inside1 <= w_inside;
    end
  end

  logic                  w_any;
  logic                  w_multi;
  logic [SEL_W-1:0]      w_win_id;
  logic [DATA_WIDTH-1:0] w_win_data;

  // Lowest index wins; a second opaque sprite marks a collision
  always_comb begin
    w_any      = 1'b0;
    w_multi    = 1'b0;
    w_win_id   = '0;
    w_win_data = TRANSP;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      if (w_opaque[s]) begin
        if (w_any) begin
          w_multi = 1'b1;
        end else begin
          w_win_id   = SEL_W'(s);
          w_win_data = w_texel[s];
        end
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid   <= 1'b0;
      r_data        <= TRANSP;
      r_hit         <= 1'b0;
      r_id          <= '0;
      r_coll        <= 1'b0;
      r_coll_sticky <= 1'b0;
    end else begin
      r_pix_valid   <= r_v1;
      r_hit         <= r_v1 && w_any;
      r_id          <= (r_v1 && w_any) ? w_win_id : '0;
      r_data        <= (r_v1 && w_any) ? w_win_data : TRANSP;
      r_coll        <= r_v1 && w_multi;
      r_coll_sticky <= (r_v1 && w_multi) || (r_coll_sticky && !i_clr_coll);
    end
  end

  assign o_pix_valid   = r_pix_valid;
  assign o_data        = r_data;
  assign o_hit         = r_hit;
  assign o_id          = r_id;
  assign o_coll        = r_coll;
  assign o_coll_sticky = r_coll_sticky;

endmodule

// File: tb/tb_sprite_layer.sv
// Scoreboard bench for sprite_layer: directed pixels push expected results,
// a negedge monitor pops and compares output, flags and 2-cycle latency.
module tb_sprite_layer;

  localparam int NS = 3;
  localparam int SS = 32;
  localparam int DW = 8;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_pix_valid;
  logic [CW-1:0] i_x, i_y;
  logic [1:0]    i_sel;
  logic          i_pos_we;
  logic [CW-1:0] i_pos_x, i_pos_y;
  logic          i_en;
  logic          i_wr;
  logic [9:0]    i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          i_clr_coll;
  logic          o_pix_valid;
  logic [DW-1:0] o_data;
  logic          o_hit;
  logic [1:0]    o_id;
  logic          o_coll;
  logic          o_coll_sticky;

  sprite_layer #(
    .NUM_SPRITES(NS), .SPRITE_SIZE(SS), .DATA_WIDTH(DW),
    .COORD_WIDTH(CW), .TRANSPARENT(0), .MEMFILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pix_valid(i_pix_valid), .i_x(i_x), .i_y(i_y),
    .i_sel(i_sel), .i_pos_we(i_pos_we), .i_pos_x(i_pos_x), .i_pos_y(i_pos_y), .i_en(i_en),
    .i_wr(i_wr), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_clr_coll(i_clr_coll),
    .o_pix_valid(o_pix_valid), .o_data(o_data), .o_hit(o_hit), .o_id(o_id),
    .o_coll(o_coll), .o_coll_sticky(o_coll_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic       hit;
    logic [1:0] id;
    logic [7:0] data;
    logic       coll;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: {hit, id, data, coll, latency}
  always @(negedge clk) begin
    if (rst_n === 1'b1 && o_pix_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pixel: got data %0h with empty queue (t=%0t)", o_data, $time);
      end else begin
        e = q.pop_front();
        check("pixel {hit,id,data,coll,lat}",
              {12'd0, o_hit, o_id, o_data, o_coll, 8'(cyc - e.cyc)},
              {12'd0, e.hit, e.id, e.data, e.coll, 8'd2});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic hit, input logic [1:0] id,
                     input logic [7:0] d, input logic coll);
    exp_t t;
    i_pix_valid = 1'b1;
    i_x = CW'(x);
    i_y = CW'(y);
    t.hit = hit; t.id = id; t.data = d; t.coll = coll; t.cyc = cyc;
    q.push_back(t);
    tick();
    i_pix_valid = 1'b0;
    i_pos_we    = 1'b0;
    i_wr        = 1'b0;
    i_clr_coll  = 1'b0;
  endtask

  task automatic set_pos(input logic [1:0] sel, input int x, input int y, input logic en);
    i_sel = sel; i_pos_x = CW'(x); i_pos_y = CW'(y); i_en = en; i_pos_we = 1'b1;
    tick();
    i_pos_we = 1'b0;
  endtask

  task automatic wr_tex(input logic [1:0] sel, input int addr, input logic [7:0] d);
    i_sel = sel; i_wr_addr = 10'(addr); i_wr_data = d; i_wr = 1'b1;
    tick();
    i_wr = 1'b0;
  endtask

  task automatic clr_pulse();
    i_clr_coll = 1'b1;
    tick();
    i_clr_coll = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    {i_pix_valid, i_x, i_y, i_sel, i_pos_we, i_pos_x, i_pos_y, i_en} = '0;
    {i_wr, i_wr_addr, i_wr_data, i_clr_coll} = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst o_pix_valid", o_pix_valid, 0);
    check("rst o_data", o_data, 0);
    check("rst o_hit", o_hit, 0);
    check("rst o_id", o_id, 0);
    check("rst o_coll", o_coll, 0);
    check("rst o_coll_sticky", o_coll_sticky, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Single sprite: corners, edges and just-outside pixels
    wr_tex(0, 0, 8'h3C);
    wr_tex(0, 31, 8'h11);
    wr_tex(0, 992, 8'h77);
    set_pos(0, 100, 50, 1'b1);
    pix(100, 50, 1, 0, 8'h3C, 0);
    pix(131, 50, 1, 0, 8'h11, 0);
    pix(132, 50, 0, 0, 8'h00, 0);
    pix(99, 50, 0, 0, 8'h00, 0);
    pix(100, 81, 1, 0, 8'h77, 0);
    pix(100, 82, 0, 0, 8'h00, 0);
    pix(100, 49, 0, 0, 8'h00, 0);
    pix(100, 50, 1, 0, 8'h3C, 0);
    repeat (3) tick();
    check("idle o_pix_valid", o_pix_valid, 0);
    check("idle o_hit forced", o_hit, 0);
    check("idle o_data forced", o_data, 0);

    // Overlap, priority and collision flags
    set_pos(0, 10, 10, 1'b1);
    set_pos(1, 10, 10, 1'b1);
    wr_tex(0, 0, 8'h00);
    wr_tex(1, 0, 8'h55);
    pix(10, 10, 1, 1, 8'h55, 0);
    repeat (3) tick();
    check("sticky clear before overlap", o_coll_sticky, 0);
    wr_tex(0, 0, 8'hAA);
    pix(10, 10, 1, 0, 8'hAA, 1);
    repeat (3) tick();
    check("sticky after overlap", o_coll_sticky, 1);
    repeat (2) tick();
    check("sticky holds", o_coll_sticky, 1);
    clr_pulse();
    check("sticky cleared", o_coll_sticky, 0);
    pix(10, 10, 1, 0, 8'hAA, 1);
    clr_pulse();
    repeat (2) tick();
    check("sticky set wins over clear", o_coll_sticky, 1);
    clr_pulse();
    check("sticky cleared again", o_coll_sticky, 0);

    // Same-cycle write and read of one texel returns old data
    set_pos(0, 10, 10, 1'b0);
    i_sel = 2'd1; i_wr_addr = 10'd0; i_wr_data = 8'h99; i_wr = 1'b1;
    pix(10, 10, 1, 1, 8'h55, 0);
    pix(10, 10, 1, 1, 8'h99, 0);

    // Position update only affects pixels presented after the write edge
    i_sel = 2'd1; i_pos_x = 11'd200; i_pos_y = 11'd200; i_en = 1'b1; i_pos_we = 1'b1;
    pix(10, 10, 1, 1, 8'h99, 0);
    pix(10, 10, 0, 0, 8'h00, 0);

    // Out-of-range select is ignored
    wr_tex(3, 0, 8'hF0);
    set_pos(3, 10, 10, 1'b1);
    pix(10, 10, 0, 0, 8'h00, 0);
    pix(200, 200, 1, 1, 8'h99, 0);

    // Right screen edge, no wrap to column 0
    wr_tex(2, 7, 8'h5A);
    wr_tex(2, 8, 8'h33);
    set_pos(2, 2040, 0, 1'b1);
    pix(2047, 0, 1, 2, 8'h5A, 0);
    pix(0, 0, 0, 0, 8'h00, 0);

    // Mid-stream reset drops in-flight pixels and clears enables
    pix(2047, 0, 1, 2, 8'h5A, 0);
    pix(2047, 0, 1, 2, 8'h5A, 0);
    pix(2047, 0, 1, 2, 8'h5A, 0);
    rst_n = 1'b0;
    #1;
    check("midrst o_pix_valid", o_pix_valid, 0);
    check("midrst o_hit", o_hit, 0);
    check("midrst o_data", o_data, 0);
    q.delete();
    tick();
    rst_n = 1'b1;
    pix(2047, 0, 0, 0, 8'h00, 0);
    pix(200, 200, 0, 0, 8'h00, 0);
    set_pos(2, 2040, 0, 1'b1);
    pix(2047, 0, 1, 2, 8'h5A, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    check("scoreboard drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
